disp_sched: RTL and testbench

Display-source scheduler feeding the 8-digit seven-segment display driver on the board top. Selects one of four 32-bit sources (PC, switch image, LED image, auxiliary word) for display, either rotating automatically on a dwell timer or following a manual selector. It inserts a blanking gap between sources and grants a one-shot alert requester temporary priority. Its `busy` output drives the display driver's `busy` input.

---
 rtl/disp_sched.sv | 175 +++++++++++++++++
 tb/tb_disp_sched.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_sched.sv
// Display-source scheduler: shows one of four 32-bit words (timed rotation or manual
// select), blanks between sources and lets a one-shot alert word pre-empt the display.
module disp_sched #(
  parameter int DWELL      = 50_000_000,
  parameter int BLANK      = 1_000_000,
  parameter int ALERT_HOLD = 100_000_000
) (
  input  logic        clk_i,
  input  logic        rst,
  input  logic        auto_en,
  input  logic [1:0]  man_sel,
  input  logic        freeze,
  input  logic [31:0] src0_data,
  input  logic [31:0] src1_data,
  input  logic [31:0] src2_data,
  input  logic [31:0] src3_data,
  input  logic        alert_req,
  input  logic [31:0] alert_data,
  output logic        alert_ack,
  output logic [31:0] disp_data,
  output logic [2:0]  disp_src,
  output logic        disp_blank,
  output logic        busy
);

  localparam int MAXDB = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int MAXP  = (MAXDB > ALERT_HOLD) ? MAXDB : ALERT_HOLD;
  localparam int CW    = (MAXP > 1) ? $clog2(MAXP) : 1;

  localparam logic [CW-1:0] DWELL_END = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK - 1);
  localparam logic [CW-1:0] ALERT_END = CW'(ALERT_HOLD - 1);

  typedef enum logic [1:0] {S_SHOW, S_BLANK, S_ALERT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    cur_sel_q, cur_sel_d;
  logic [1:0]    next_sel_q, next_sel_d;
  logic          armed_q, armed_d;
  logic          commit_q, commit_d;
  logic [31:0]   alert_word_q, alert_word_d;

  logic [31:0]   disp_data_q, disp_data_d;
  logic [2:0]    disp_src_q, disp_src_d;
  logic          disp_blank_q, disp_blank_d;
  logic          busy_q, busy_d;
  logic          ack_q, ack_d;

  logic          accept;
  logic          switch_req;
  logic [31:0]   src [4];

  always_comb begin
    src[0] = src0_data;
    src[1] = src1_data;
    src[2] = src2_data;
    src[3] = src3_data;
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q      <= S_SHOW;
      cnt_q        <= '0;
      cur_sel_q    <= '0;
      next_sel_q   <= '0;
      armed_q      <= 1'b1;
      commit_q     <= 1'b0;
      alert_word_q <= '0;
      disp_data_q  <= '0;
      disp_src_q   <= '0;
      disp_blank_q <= 1'b0;
      busy_q       <= 1'b0;
      ack_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_sel_q    <= cur_sel_d;
      next_sel_q   <= next_sel_d;
      armed_q      <= armed_d;
      commit_q     <= commit_d;
      alert_word_q <= alert_word_d;
      disp_data_q  <= disp_data_d;
      disp_src_q   <= disp_src_d;
      disp_blank_q <= disp_blank_d;
      busy_q       <= busy_d;
      ack_q        <= ack_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cur_sel_d    = cur_sel_q;
    next_sel_d   = next_sel_q;
    commit_d     = commit_q;
    alert_word_d = alert_word_q;
    armed_d      = armed_q | ~alert_req;
    accept       = 1'b0;
    switch_req   = 1'b0;
    unique case (state_q)
      S_SHOW: begin
        if (!auto_en) begin
          cnt_d = '0;
          if (!freeze && (man_sel != cur_sel_q)) begin
            next_sel_d = man_sel;
            switch_req = 1'b1;
          end
        end else if (!freeze) begin
          if (cnt_q == DWELL_END) begin
            cnt_d      = '0;
            next_sel_d = cur_sel_q + 2'd1;
            switch_req = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        if (switch_req) state_d = S_BLANK;
      end
      S_BLANK: begin
        if (cnt_q == BLANK_END) begin
          cnt_d     = '0;
          cur_sel_d = next_sel_q;
          state_d   = S_SHOW;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_ALERT: begin
        if (cnt_q == ALERT_END) begin
          cnt_d   = '0;
          state_d = S_SHOW;
          if (commit_q) cur_sel_d = next_sel_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_SHOW;
    endcase
    // Alert overrides any transition decided above but keeps the pending next_sel,
    // which is committed on exit if a switch was interrupted or pre-empted.
    if (alert_req && armed_q && (state_q != S_ALERT)) begin
      accept       = 1'b1;
      armed_d      = 1'b0;
      alert_word_d = alert_data;
      commit_d     = (state_q == S_BLANK) || switch_req;
      cnt_d        = '0;
      cur_sel_d    = cur_sel_q;
      state_d      = S_ALERT;
    end
  end

  always_comb begin
    disp_data_d  = disp_data_q;
    disp_src_d   = {1'b0, cur_sel_d};
    disp_blank_d = (state_d == S_BLANK);
    busy_d       = (state_d == S_ALERT);
    ack_d        = accept;
    if (state_d == S_ALERT) begin
      disp_src_d  = 3'd4;
      disp_data_d = alert_word_d;
    end else if (state_q != S_SHOW) begin
      if (state_d == S_SHOW) disp_data_d = src[cur_sel_d];
    end else if (!freeze) begin
      disp_data_d = src[cur_sel_q];
    end
  end

  assign alert_ack  = ack_q;
  assign disp_data  = disp_data_q;
  assign disp_src   = disp_src_q;
  assign disp_blank = disp_blank_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_disp_sched.sv
// Bench for disp_sched: a vector table for auto rotation, directed corner sequences and a
// randomized run compared against a countdown-based behavioural model.
module tb_disp_sched;

  localparam int DWELL = 4;
  localparam int BLANK = 2;
  localparam int HOLD  = 3;

  logic        clk_i;
  logic        rst;
  logic        auto_en;
  logic [1:0]  man_sel;
  logic        freeze;
  logic [31:0] src_v [4];
  logic        alert_req;
  logic [31:0] alert_data;
  logic        alert_ack;
  logic [31:0] disp_data;
  logic [2:0]  disp_src;
  logic        disp_blank;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  disp_sched #(.DWELL(DWELL), .BLANK(BLANK), .ALERT_HOLD(HOLD)) dut (
    .clk_i      (clk_i),
    .rst        (rst),
    .auto_en    (auto_en),
    .man_sel    (man_sel),
    .freeze     (freeze),
    .src0_data  (src_v[0]),
    .src1_data  (src_v[1]),
    .src2_data  (src_v[2]),
    .src3_data  (src_v[3]),
    .alert_req  (alert_req),
    .alert_data (alert_data),
    .alert_ack  (alert_ack),
    .disp_data  (disp_data),
    .disp_src   (disp_src),
    .disp_blank (disp_blank),
    .busy       (busy)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Behavioural model: countdowns of cycles remaining in the current phase.
  localparam int M_SHOW = 0, M_GAP = 1, M_ALERT = 2;
  int          m_mode, m_cur, m_target, m_show_left, m_left;
  bit          m_armed, m_commit, m_ack;
  logic [31:0] m_data;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endfunction

  task automatic enter_show(input int c);
    m_cur       = c;
    m_mode      = M_SHOW;
    m_show_left = DWELL;
    m_data      = src_v[c];
  endtask

  task automatic model_step();
    bit acc, sw;
    int nxt;
    if (rst) begin
      m_mode = M_SHOW; m_cur = 0; m_target = 0; m_show_left = DWELL; m_left = 0;
      m_armed = 1; m_commit = 0; m_ack = 0; m_data = '0;
      return;
    end
    acc     = alert_req && m_armed && (m_mode != M_ALERT);
    m_armed = acc ? 1'b0 : (m_armed || !alert_req);
    m_ack   = acc;
    sw      = 0;
    nxt     = m_target;
    if (m_mode == M_SHOW && !freeze) begin
      if (auto_en) begin
        if (m_show_left == 1) begin sw = 1; nxt = (m_cur + 1) % 4; end
      end else if (int'(man_sel) != m_cur) begin
        sw = 1; nxt = int'(man_sel);
      end
    end
    if (acc) begin
      m_commit = (m_mode == M_GAP) || sw;
      m_target = nxt;
      m_mode   = M_ALERT;
      m_left   = HOLD;
      m_data   = alert_data;
    end else begin
      case (m_mode)
        M_SHOW: begin
          if (!freeze) m_data = src_v[m_cur];
          if (sw) begin
            m_target = nxt; m_mode = M_GAP; m_left = BLANK;
          end else if (!auto_en) m_show_left = DWELL;
          else if (!freeze) m_show_left--;
        end
        M_GAP:   if (m_left == 1) enter_show(m_target); else m_left--;
        default: if (m_left == 1) enter_show(m_commit ? m_target : m_cur); else m_left--;
      endcase
    end
  endtask

  task automatic chk_model();
    chk("model_data",  disp_data, m_data);
    chk("model_src",   32'(disp_src), (m_mode == M_ALERT) ? 32'd4 : 32'(m_cur));
    chk("model_blank", 32'(disp_blank), 32'(m_mode == M_GAP));
    chk("model_busy",  32'(busy), 32'(m_mode == M_ALERT));
    chk("model_ack",   32'(alert_ack), 32'(m_ack));
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_step();
    #1;
    chk_model();
  endtask

  task automatic default_srcs();
    for (int k = 0; k < 4; k++) src_v[k] = 32'hA000_0000 | 32'(k);
  endtask

  task automatic do_reset(input logic au, input logic [1:0] ms);
    rst = 1'b1; auto_en = au; man_sel = ms; freeze = 1'b0;
    alert_req = 1'b0; alert_data = '0;
    default_srcs();
    tick();
    tick();
    chk("rst_data",  disp_data, 32'h0);
    chk("rst_src",   32'(disp_src), 32'd0);
    chk("rst_blank", 32'(disp_blank), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_ack",   32'(alert_ack), 32'd0);
    rst = 1'b0;
  endtask

  typedef struct {
    logic        auto_en;
    logic [1:0]  man_sel;
    logic        freeze;
    logic        alert_req;
    int          exp_src;   // -1: not checked (blank gap)
    logic        exp_blank;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tbl [25];

  initial begin
    int idx;
    // Auto rotation from reset: per source 4 shown cycles then 2 blank cycles.
    idx = 0;
    for (int n = 0; n < 4; n++) begin
      for (int k = 0; k < 6; k++) begin
        tbl[idx].auto_en   = 1'b1;
        tbl[idx].man_sel   = 2'd0;
        tbl[idx].freeze    = 1'b0;
        tbl[idx].alert_req = 1'b0;
        tbl[idx].exp_blank = (k >= 4);
        tbl[idx].exp_src   = (k >= 4) ? -1 : n;
        tbl[idx].exp_data  = 32'hA000_0000 | 32'(n);
        idx++;
      end
    end
    tbl[24] = '{1'b1, 2'd0, 1'b0, 1'b0, 0, 1'b0, 32'hA000_0000};
    tbl[0].exp_data = 32'h0;

    clk_i = 1'b0;
    do_reset(1'b1, 2'd0);
    for (int i = 0; i < 25; i++) begin
      if (i > 0) begin
        auto_en = tbl[i].auto_en; man_sel = tbl[i].man_sel;
        freeze = tbl[i].freeze; alert_req = tbl[i].alert_req;
        tick();
      end
      chk("tbl_data",  disp_data, tbl[i].exp_data);
      chk("tbl_blank", 32'(disp_blank), 32'(tbl[i].exp_blank));
      chk("tbl_busy",  32'(busy), 32'd0);
      if (tbl[i].exp_src >= 0) chk("tbl_src", 32'(disp_src), 32'(tbl[i].exp_src));
    end

    // Manual select; man_sel wiggled inside the gap must not matter.
    do_reset(1'b0, 2'd0);
    tick();
    chk("man_pre_data", disp_data, 32'hA000_0000);
    man_sel = 2'd2; tick();
    chk("man_blank1", 32'(disp_blank), 32'd1);
    man_sel = 2'd3; tick();
    chk("man_blank2", 32'(disp_blank), 32'd1);
    man_sel = 2'd2; tick();
    chk("man_new_blank", 32'(disp_blank), 32'd0);
    chk("man_new_src",   32'(disp_src), 32'd2);
    chk("man_new_data",  disp_data, 32'hA000_0002);
    tick();
    chk("man_stay_src",  32'(disp_src), 32'd2);

    // Freeze at dwell count 2 for 10 cycles, with the source changing underneath.
    do_reset(1'b1, 2'd0);
    tick(); tick();
    freeze = 1'b1; src_v[0] = 32'h1234_5678;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("frz_data",  disp_data, 32'hA000_0000);
      chk("frz_blank", 32'(disp_blank), 32'd0);
    end
    freeze = 1'b0; src_v[0] = 32'hA000_0000;
    tick();
    chk("frz_rel_show",  32'(disp_blank), 32'd0);
    tick();
    chk("frz_rel_blank", 32'(disp_blank), 32'd1);

    // Alert coinciding with dwell expiry; request held across its own ack.
    do_reset(1'b1, 2'd0);
    tick(); tick(); tick();
    alert_req = 1'b1; alert_data = 32'hDEAD_BEEF;
    tick();
    chk("al_ack",   32'(alert_ack), 32'd1);
    chk("al_src",   32'(disp_src), 32'd4);
    chk("al_busy",  32'(busy), 32'd1);
    chk("al_data",  disp_data, 32'hDEAD_BEEF);
    chk("al_blank", 32'(disp_blank), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("al_hold_ack", 32'(alert_ack), 32'd0);
      chk("al_hold_src", 32'(disp_src), 32'd4);
      chk("al_hold_busy", 32'(busy), 32'd1);
    end
    tick();
    chk("al_exit_src",   32'(disp_src), 32'd1);
    chk("al_exit_blank", 32'(disp_blank), 32'd0);
    chk("al_exit_busy",  32'(busy), 32'd0);
    chk("al_exit_data",  disp_data, 32'hA000_0001);
    tick();
    chk("al_noreack", 32'(alert_ack), 32'd0);
    alert_req = 1'b0; tick();
    chk("al_drop_noack", 32'(alert_ack), 32'd0);
    alert_req = 1'b1; alert_data = 32'h0BAD_F00D; tick();
    chk("al_reack",      32'(alert_ack), 32'd1);
    chk("al_reack_data", disp_data, 32'h0BAD_F00D);
    alert_req = 1'b0;
    tick(); tick(); tick();
    chk("al2_exit_src",   32'(disp_src), 32'd1);
    chk("al2_exit_blank", 32'(disp_blank), 32'd0);

    // Reset in the second alert cycle.
    do_reset(1'b1, 2'd0);
    alert_req = 1'b1; alert_data = 32'hCAFE_F00D;
    tick();
    chk("ra_ack", 32'(alert_ack), 32'd1);
    tick();
    chk("ra_in_alert", 32'(disp_src), 32'd4);
    rst = 1'b1; alert_req = 1'b0;
    tick();
    chk("ra_data", disp_data, 32'h0);
    chk("ra_src",  32'(disp_src), 32'd0);
    chk("ra_busy", 32'(busy), 32'd0);
    chk("ra_ack0", 32'(alert_ack), 32'd0);
    rst = 1'b0;
    tick();
    chk("ra_after_data", disp_data, 32'hA000_0000);

    // Randomized run against the model.
    do_reset(1'b1, 2'd0);
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 59) == 0) auto_en = ~auto_en;
      if ($urandom_range(0, 11) == 0) man_sel = 2'($urandom);
      freeze = ($urandom_range(0, 7) == 0);
      if (alert_ack) alert_req = ($urandom_range(0, 3) == 0);
      else if (!alert_req && $urandom_range(0, 39) == 0) begin
        alert_req = 1'b1; alert_data = $urandom;
      end
      if ($urandom_range(0, 19) == 0) src_v[$urandom_range(0, 3)] = $urandom;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
